card_dealer: RTL and testbench

//  Downstream of the deck shuffler. After the shuffle, deals cards one at a time from the
//  52-entry deck RAM to the game FSM. Each card is fetched on request through the shared
//  RAM read port. Tracks the deck pointer and remaining count, and flags an exhausted deck.

---
 rtl/card_pkg.sv | 19 +
 rtl/card_dealer_if.sv | 27 ++
 rtl/card_points.sv | 15 +
 rtl/card_dealer.sv | 83 ++++++++
 tb/tb_card_dealer.sv | 181 ++++++++++++++++++
 5 files changed

// File: rtl/card_pkg.sv
// Shared encodings and constants for the card dealer slice.
package card_pkg;

    typedef enum logic [2:0] {
        IDLE    = 3'd0,
        READY   = 3'd1,
        FETCH   = 3'd2,
        CAPTURE = 3'd3,
        DONE    = 3'd4,
        EMPTY   = 3'd5
    } state_t;

    localparam int DECK_SIZE = 52;
    localparam int DATA_W    = 4;
    localparam int ACE       = 1;
    localparam int JACK      = 11;
    localparam int KING      = 13;

endpackage

// File: rtl/card_dealer_if.sv
// Game-FSM / deck-RAM side bus of the card dealer; slave is the dealer itself.
interface card_dealer_if #(
    parameter int ADDR_W = 6,
    parameter int DATA_W = card_pkg::DATA_W
);
    logic              deckLoad;
    logic              req;
    logic [DATA_W-1:0] memData;
    logic [ADDR_W-1:0] addr;
    logic              memClock;
    logic              ready;
    logic [DATA_W-1:0] cardValue;
    logic              cardValid;
    logic [ADDR_W-1:0] cardsLeft;
    logic              deckEmpty;
    logic [3:0]        cardPoints;

    modport master (
        output deckLoad, req, memData,
        input  addr, memClock, ready, cardValue, cardValid, cardsLeft, deckEmpty, cardPoints
    );

    modport slave (
        input  deckLoad, req, memData,
        output addr, memClock, ready, cardValue, cardValid, cardsLeft, deckEmpty, cardPoints
    );
endinterface

// File: rtl/card_points.sv
// Combinational card-code to game-points map: face cards count 10, all else its own code.
module card_points
    import card_pkg::*;
#(
    parameter int CODE_W = card_pkg::DATA_W
) (
    input  logic [CODE_W-1:0] code,
    output logic [3:0]        points
);
    always_comb begin
        points = 4'(code);
        if (code >= CODE_W'(JACK) && code <= CODE_W'(KING))
            points = 4'd10;
    end
endmodule

// File: rtl/card_dealer.sv
// Deals shuffled cards one per request from the deck RAM to the game FSM.
// Optional CARD_POINTS_EN adds a registered points value alongside each dealt card.
module card_dealer #(
    parameter int DECK_SIZE = card_pkg::DECK_SIZE,
    parameter int ADDR_W    = 6,
    parameter int DATA_W    = card_pkg::DATA_W,
    parameter int BASE_ADDR = 0
) (
    input  logic         clock,
    input  logic         reset,
    card_dealer_if.slave bus
);
    import card_pkg::*;

    state_t            state, state_nxt;
    logic [ADDR_W-1:0] ptr;
    logic [ADDR_W-1:0] left;
    logic [DATA_W-1:0] value;

    always_ff @(posedge clock) begin
        if (reset) begin
            state <= IDLE;
            ptr   <= ADDR_W'(BASE_ADDR);
            left  <= '0;
            value <= '0;
        end else begin
            state <= state_nxt;
            // A rewind aborts any fetch in flight, so the capture is skipped.
            if (bus.deckLoad) begin
                ptr  <= ADDR_W'(BASE_ADDR);
                left <= ADDR_W'(DECK_SIZE);
            end else if (state == CAPTURE) begin
                value <= bus.memData;
                ptr   <= ptr + ADDR_W'(1);
                left  <= left - ADDR_W'(1);
            end
        end
    end

    always_comb begin
        state_nxt = state;
        case (state)
            IDLE:    state_nxt = IDLE;
            READY:   if (bus.req) state_nxt = FETCH;
            FETCH:   state_nxt = CAPTURE;
            CAPTURE: state_nxt = DONE;
            DONE:    state_nxt = (left == '0) ? EMPTY : READY;
            EMPTY:   state_nxt = EMPTY;
            default: state_nxt = IDLE;
        endcase
        if (bus.deckLoad)
            state_nxt = READY;
    end

    assign bus.addr      = ptr;
    assign bus.memClock  = (state == FETCH);
    assign bus.ready     = (state == READY);
    assign bus.cardValid = (state == DONE);
    assign bus.cardValue = value;
    assign bus.cardsLeft = left;
    assign bus.deckEmpty = (left == '0);

`ifdef CARD_POINTS_EN
    logic [3:0] pts, pts_q;

    card_points #(.CODE_W(DATA_W)) u_points (
        .code   (bus.memData),
        .points (pts)
    );

    always_ff @(posedge clock) begin
        if (reset)
            pts_q <= '0;
        else if (!bus.deckLoad && state == CAPTURE)
            pts_q <= pts;
    end

    assign bus.cardPoints = pts_q;
`else
    assign bus.cardPoints = '0;
`endif

endmodule

// File: tb/tb_card_dealer.sv
// Directed bench for card_dealer: reset, single deal, full deck, rewind mid-fetch, reset mid-fetch.
module tb_card_dealer;
    logic clock = 1'b0;
    logic reset;
    int   nvec = 0;
    int   nerr = 0;
    logic [3:0] ram [64];

    card_dealer_if #(.ADDR_W(6), .DATA_W(4)) bus ();

    card_dealer #(.DECK_SIZE(52), .ADDR_W(6), .DATA_W(4), .BASE_ADDR(0)) dut (
        .clock (clock),
        .reset (reset),
        .bus   (bus)
    );

    always #5 clock = ~clock;

    // Deck RAM model: one-cycle read latency after the strobe.
    always @(posedge clock)
        if (bus.memClock) bus.memData <= ram[bus.addr];

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        nvec++;
        if (got !== exp) begin
            nerr++;
            $display("FAIL %s: got %0d expected %0d", tag, got, exp);
        end
    endtask

    task automatic tick();
        @(posedge clock);
        #1;
    endtask

    function automatic logic [3:0] code_at(input int i);
        case (i)
            0: code_at = 4'd7;
            1: code_at = 4'd1;
            2: code_at = 4'd10;
            3: code_at = 4'd12;
            4: code_at = 4'd13;
            default: code_at = 4'(i % 16);
        endcase
    endfunction

    function automatic logic [3:0] exp_pts(input logic [3:0] c);
`ifdef CARD_POINTS_EN
        exp_pts = (c >= 4'd11 && c <= 4'd13) ? 4'd10 : c;
`else
        exp_pts = 4'd0;
`endif
    endfunction

    task automatic chk_reset_state(input string tag);
        chk({tag, "_ready"},  bus.ready,      0);
        chk({tag, "_empty"},  bus.deckEmpty,  1);
        chk({tag, "_left"},   bus.cardsLeft,  0);
        chk({tag, "_addr"},   bus.addr,       0);
        chk({tag, "_memclk"}, bus.memClock,   0);
        chk({tag, "_valid"},  bus.cardValid,  0);
        chk({tag, "_value"},  bus.cardValue,  0);
        chk({tag, "_pts"},    bus.cardPoints, 0);
    endtask

    initial begin
        int seen;
        for (int i = 0; i < 64; i++) ram[i] = code_at(i);
        reset = 1'b1; bus.deckLoad = 1'b0; bus.req = 1'b0;
        tick(); tick();
        chk_reset_state("rst");

        // 1: rewind after reset
        reset = 1'b0; bus.deckLoad = 1'b1;
        tick();
        bus.deckLoad = 1'b0;
        chk("load_left",  bus.cardsLeft, 52);
        chk("load_ready", bus.ready,     1);
        chk("load_empty", bus.deckEmpty, 0);
        chk("load_addr",  bus.addr,      0);

        // 2: single one-cycle request
        bus.req = 1'b1;
        tick();
        bus.req = 1'b0;
        chk("d0_memclk", bus.memClock, 1);
        chk("d0_addr",   bus.addr,     0);
        chk("d0_ready",  bus.ready,    0);
        tick();
        chk("d0_memclk_off", bus.memClock,  0);
        chk("d0_novalid",    bus.cardValid, 0);
        tick();
        chk("d0_valid", bus.cardValid,  1);
        chk("d0_value", bus.cardValue,  7);
        chk("d0_left",  bus.cardsLeft,  51);
        chk("d0_pts",   bus.cardPoints, exp_pts(4'd7));
        tick();
        chk("d0_valid_off", bus.cardValid, 0);
        chk("d0_back",      bus.ready,     1);

        // 3: req held high, remaining 51 cards at one per 4 cycles
        bus.req = 1'b1;
        for (int n = 1; n < 52; n++) begin
            tick();
            chk($sformatf("d%0d_memclk", n), bus.memClock, 1);
            chk($sformatf("d%0d_addr", n),   bus.addr,     n);
            tick();
            tick();
            chk($sformatf("d%0d_valid", n), bus.cardValid,  1);
            chk($sformatf("d%0d_value", n), bus.cardValue,  code_at(n));
            chk($sformatf("d%0d_pts", n),   bus.cardPoints, exp_pts(code_at(n)));
            chk($sformatf("d%0d_left", n),  bus.cardsLeft,  51 - n);
            chk($sformatf("d%0d_empty", n), bus.deckEmpty,  (n == 51) ? 1 : 0);
            tick();
            chk($sformatf("d%0d_ready", n), bus.ready, (n == 51) ? 0 : 1);
        end
        chk("exh_empty", bus.deckEmpty, 1);
        seen = 0;
        for (int c = 0; c < 8; c++) begin
            if (bus.memClock || bus.cardValid || bus.ready) seen++;
            tick();
        end
        chk("exh_ignored", seen, 0);
        bus.req = 1'b0;

        // 4: rewind from EMPTY, then rewind during CAPTURE
        bus.deckLoad = 1'b1;
        tick();
        bus.deckLoad = 1'b0;
        chk("reload_ready", bus.ready,     1);
        chk("reload_left",  bus.cardsLeft, 52);
        bus.req = 1'b1;
        tick();
        bus.req = 1'b0;
        tick();
        bus.deckLoad = 1'b1;
        tick();
        bus.deckLoad = 1'b0;
        chk("abort_ready", bus.ready,     1);
        chk("abort_valid", bus.cardValid, 0);
        chk("abort_left",  bus.cardsLeft, 52);
        chk("abort_addr",  bus.addr,      0);
        chk("abort_value", bus.cardValue, code_at(51));
        seen = 0;
        for (int c = 0; c < 3; c++) begin
            tick();
            if (bus.cardValid) seen++;
        end
        chk("abort_nopulse", seen, 0);

        // deckLoad wins over a simultaneous req
        bus.deckLoad = 1'b1; bus.req = 1'b1;
        tick();
        bus.deckLoad = 1'b0; bus.req = 1'b0;
        chk("loadreq_memclk", bus.memClock, 0);
        chk("loadreq_ready",  bus.ready,    1);

        // 5: reset during FETCH
        bus.req = 1'b1;
        tick();
        chk("rf_memclk", bus.memClock, 1);
        reset = 1'b1;
        tick();
        reset = 1'b0;
        chk_reset_state("rf");
        seen = 0;
        for (int c = 0; c < 6; c++) begin
            tick();
            if (bus.memClock || bus.ready || bus.cardValid) seen++;
        end
        chk("rf_req_ignored", seen, 0);
        bus.req = 1'b0;
        bus.deckLoad = 1'b1;
        tick();
        bus.deckLoad = 1'b0;
        chk("rf_reload_ready", bus.ready, 1);

        $display("== %0d vectors applied, %0d miscompares ==", nvec, nerr);
        $finish;
    end
endmodule
